// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the universal-gate self-test sequencer.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned ERR_W       = 8;

    // Golden truth table of the gate stage, returned as {nand, nor}.
    function automatic logic [1:0] expect_gate(input logic a, input logic b);
        return {~(a & b), ~(a | b)};
    endfunction

endpackage

// File: rtl/gate_bist_sequencer.sv
// Drives all {a,b} vectors into the NAND/NOR gate, samples after a settle window
// and accumulates a per-vector failure mask plus a saturating mismatch count.
module gate_bist_sequencer
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   a,
    output logic                   b,
    input  logic                   nand_in,
    input  logic                   nor_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_VECTORS-1:0] fail_mask,
    output logic [ERR_W-1:0]       err_count
);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         settle_q, settle_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         pass_cnt_q, pass_cnt_d;
    logic                     a_d, b_d, busy_d, done_d, pass_d;
    logic [NUM_VECTORS-1:0]   fail_mask_d;
    logic [ERR_W-1:0]         err_count_d;

    logic [1:0]               exp_c;
    logic                     miss_nand_c, miss_nor_c;
    logic [ERR_W:0]           err_sum_c;
    logic [NUM_VECTORS-1:0]   hit_c;
    logic                     last_c;

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            a          <= a_d;
            b          <= b_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_mask  <= fail_mask_d;
            err_count  <= err_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        idx_d       = idx_q;
        pass_cnt_d  = pass_cnt_q;
        a_d         = a;
        b_d         = b;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_mask_d = fail_mask;
        err_count_d = err_count;

        exp_c       = expect_gate(a, b);
        miss_nand_c = nand_in ^ exp_c[1];
        miss_nor_c  = nor_in ^ exp_c[0];
        err_sum_c   = {1'b0, err_count} + {{ERR_W{1'b0}}, miss_nand_c}
                                        + {{ERR_W{1'b0}}, miss_nor_c};
        hit_c       = '0;
        hit_c[idx_q] = miss_nand_c | miss_nor_c;
        last_c      = (idx_q == IDX_W'(NUM_VECTORS - 1)) &&
                      (pass_cnt_q == CNT_W'(NUM_PASSES - 1));

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d     = SETTLE;
                    busy_d      = 1'b1;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    idx_d       = '0;
                    pass_cnt_d  = '0;
                    settle_d    = '0;
                    fail_mask_d = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                fail_mask_d = fail_mask | hit_c;
                err_count_d = err_sum_c[ERR_W] ? '1 : err_sum_c[ERR_W-1:0];
                if (last_c) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_mask_d == '0);
                end else begin
                    // Vector index wraps naturally in IDX_W bits
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                        pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end
                    {a_d, b_d} = idx_d;
                    settle_d   = '0;
                    state_d    = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
